wb_stage: RTL
=============

Name: wb_stage

Overview:
- Write-back stage: takes one retired-instruction packet per handshake from the execute stage and completes loads through a valid/ready data-memory port.
- Aligns and sign-extends load data, then issues exactly one write-back per instruction to the integer register file and CSR file write ports.
- Emits a commit pulse carrying the PC.
- Sits directly upstream of the register file / CSR file and directly downstream of the execute stage.

Parameters:
XLEN, 32, datapath and address width
ADDR_WIDTH, 5, register-file index width

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  execute packet valid
in_ready  out  1  stage can accept packet
in_pc  in  XLEN  instruction PC
in_rd  in  ADDR_WIDTH  destination register
in_rd_wen  in  1  instruction writes rd
in_result  in  XLEN  ALU/CSR-read result, or load address when in_is_load
in_is_load  in  1  packet is a load
in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
in_csr_wen  in  1  instruction writes a CSR
in_csr_addr  in  12  CSR address
in_csr_wdata  in  XLEN  CSR write value
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  XLEN  word-aligned read address
mem_rsp_valid  in  1  read data valid
mem_rsp_data  in  XLEN  read word
rf_wen  out  1  register-file write enable
rf_waddr  out  ADDR_WIDTH  write index
rf_wdata  out  XLEN  write data
csr_wen  out  1  CSR write enable
csr_waddr  out  12  CSR address
csr_wdata  out  XLEN  CSR data
commit_valid  out  1  one-cycle retire pulse
commit_pc  out  XLEN  retired PC
load_misalign  out  1  one-cycle pulse with commit_valid on a misaligned load

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - State = IDLE.
  - Output values in reset: in_ready=1; mem_req_valid, rf_wen, csr_wen, commit_valid, load_misalign = 0.
  - mem_req_addr, rf_waddr, rf_wdata, csr_waddr, csr_wdata, commit_pc = 0.
- All outputs are registered except in_ready, which is (state==IDLE).
- Packet capture: an accepted packet (in_valid & in_ready) is latched whole into an internal register.
- State IDLE:
  - Accept with !in_is_load -> COMMIT.
  - Accept with in_is_load and aligned address -> MEM_REQ.
  - Accept with in_is_load and misaligned address -> COMMIT with misalign flag set.
  - Misaligned means: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
- State MEM_REQ:
  - mem_req_valid=1, mem_req_addr = {addr[XLEN-1:2], 2'b00}.
  - Held stable until mem_req_ready, then -> MEM_WAIT.
- State MEM_WAIT:
  - Waits any number of cycles for mem_rsp_valid; captures the aligned/extended data, then -> COMMIT.
  - mem_rsp_valid outside MEM_WAIT is ignored.
- Load data extraction:
  - Byte = mem_rsp_data[8*addr[1:0]+:8].
  - Half = mem_rsp_data[16*addr[1]+:16].
  - LB/LH sign-extend to XLEN; LBU/LHU zero-extend.
  - Undefined funct3 is treated as LW.
- State COMMIT, for exactly one cycle:
  - commit_valid=1, commit_pc=latched pc.
  - rf_wen = rd_wen & (rd!=0) & !misalign.
  - rf_wdata = load data for loads, else in_result.
  - csr_wen = csr_wen_latched & !misalign; load_misalign = misalign.
  - Then -> IDLE.
- Latency:
  - Non-load: accept at cycle N, write-back visible cycle N+1; next accept possible at N+2.
  - Load: request in N+1, minimum write-back in N+3 (zero-wait ready and response).
- Write enables are pulses; rf_wen/csr_wen/commit_valid are never high for two consecutive cycles.
- rd==0 with rd_wen: commit occurs, rf_wen stays 0.
- Reset mid-load: abandon the transaction, drop mem_req_valid next cycle, go to IDLE. A later stray mem_rsp_valid is ignored.

Decomposition:
- Shared package holds:
  - Load funct3 encodings (LB, LH, LW, LBU, LHU).
  - State enum (IDLE, MEM_REQ, MEM_WAIT, COMMIT).
  - XLEN default.
- One sub-module is natural: wb_load_align, purely combinational (funct3, addr[1:0], raw word -> extended data, misalign flag).

Test Plan:
- ALU op: pc=0x80000000, rd=5, rd_wen=1, result=0x1234 -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234, commit_pc=0x80000000; in_ready low for one cycle.
- LB: addr=0x80001003, memory word 0x80FF7F01 with ready and response each delayed 2 cycles -> mem_req_addr=0x80001000; rf_wdata=0xFFFFFF80 one cycle after the response.
- LHU: addr=0x80001002, word 0x8001FFFF -> rf_wdata=0x00008001. Same case as LH -> 0xFFFF8001.
- Misaligned LW: addr=0x80001001 -> no mem_req_valid, commit_valid=1, load_misalign=1, rf_wen=0 in the next cycle.
- CSR write: csr_wen=1, addr=0x305, wdata=0x80000100, rd=0 -> csr_wen=1 with those values, rf_wen=0, single commit pulse.
- rst asserted in MEM_WAIT, then a mem_rsp_valid arrives two cycles later -> no rf_wen or commit_valid; in_ready=1 the cycle after reset releases.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared types for the write-back stage:
// load funct3 codes, FSM states, default width.
package wb_stage_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    MEM_REQ,
    MEM_WAIT,
    COMMIT
  } wb_state_t;

endpackage

// File: rtl/wb_stage_if.sv
// Execute packet, data-memory read port and
// register/CSR write-back bundle of the WB stage.
interface wb_stage_if
  import wb_stage_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int ADDR_WIDTH = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [XLEN-1:0]       in_pc;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic                  in_rd_wen;
  logic [XLEN-1:0]       in_result;
  logic                  in_is_load;
  logic [2:0]            in_funct3;
  logic                  in_csr_wen;
  logic [11:0]           in_csr_addr;
  logic [XLEN-1:0]       in_csr_wdata;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [XLEN-1:0]       mem_req_addr;
  logic                  mem_rsp_valid;
  logic [XLEN-1:0]       mem_rsp_data;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [XLEN-1:0]       rf_wdata;
  logic                  csr_wen;
  logic [11:0]           csr_waddr;
  logic [XLEN-1:0]       csr_wdata;
  logic                  commit_valid;
  logic [XLEN-1:0]       commit_pc;
  logic                  load_misalign;

  modport slave (
    input  in_valid, in_pc, in_rd, in_rd_wen,
    input  in_result, in_is_load, in_funct3,
    input  in_csr_wen, in_csr_addr, in_csr_wdata,
    input  mem_req_ready, mem_rsp_valid,
    input  mem_rsp_data,
    output in_ready, mem_req_valid, mem_req_addr,
    output rf_wen, rf_waddr, rf_wdata,
    output csr_wen, csr_waddr, csr_wdata,
    output commit_valid, commit_pc, load_misalign
  );

  modport master (
    output in_valid, in_pc, in_rd, in_rd_wen,
    output in_result, in_is_load, in_funct3,
    output in_csr_wen, in_csr_addr, in_csr_wdata,
    output mem_req_ready, mem_rsp_valid,
    output mem_rsp_data,
    input  in_ready, mem_req_valid, mem_req_addr,
    input  rf_wen, rf_waddr, rf_wdata,
    input  csr_wen, csr_waddr, csr_wdata,
    input  commit_valid, commit_pc, load_misalign
  );

endinterface

// File: rtl/wb_load_align.sv
// Load lane select and sign/zero extension,
// plus the misalignment check for a load type.
module wb_load_align
  import wb_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b        = raw[{addr, 3'b000} +: 8];
    h        = raw[{addr[1], 4'b0000} +: 16];
    data     = raw;
    misalign = 1'b0;
    unique case (1'b1)
      (funct3 == F3_LB):
        data = {{(XLEN-8){b[7]}}, b};
      (funct3 == F3_LBU):
        data = {{(XLEN-8){1'b0}}, b};
      (funct3 == F3_LH): begin
        data     = {{(XLEN-16){h[15]}}, h};
        misalign = addr[0];
      end
      (funct3 == F3_LHU): begin
        data     = {{(XLEN-16){1'b0}}, h};
        misalign = addr[0];
      end
      // LW and any undefined encoding
      default:
        misalign = |addr;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: completes loads over the data
// port, then retires one packet into RF/CSR files.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int ADDR_WIDTH = 5
) (
  input logic      clk,
  input logic      rst,
  wb_stage_if.slave bus
);

  wb_state_t state_q, state_d;

  logic [XLEN-1:0]       pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  rdw_q, rdw_d;
  logic [1:0]            lo_q, lo_d;
  logic [2:0]            f3_q, f3_d;
  logic                  cw_q, cw_d;
  logic [11:0]           ca_q, ca_d;
  logic [XLEN-1:0]       cd_q, cd_d;

  logic                  mrv_q, mrv_d;
  logic [XLEN-1:0]       mra_q, mra_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
  logic                  csr_wen_q, csr_wen_d;
  logic [11:0]           csr_waddr_q, csr_waddr_d;
  logic [XLEN-1:0]       csr_wdata_q, csr_wdata_d;
  logic                  cv_q, cv_d;
  logic [XLEN-1:0]       cpc_q, cpc_d;
  logic                  mis_q, mis_d;

  logic                  idle;
  logic [2:0]            a_f3;
  logic [1:0]            a_lo;
  logic [XLEN-1:0]       ld_data;
  logic                  ld_mis;

  logic                  go;
  logic                  g_mis;
  logic [XLEN-1:0]       g_data;
  logic [XLEN-1:0]       s_pc;
  logic [ADDR_WIDTH-1:0] s_rd;
  logic                  s_rdw;
  logic                  s_cw;
  logic [11:0]           s_ca;
  logic [XLEN-1:0]       s_cd;

  assign idle = (state_q == IDLE);

  // While idle the live packet is decoded,
  // afterwards the latched copy.
  assign a_f3  = idle ? bus.in_funct3 : f3_q;
  assign a_lo  = idle ? bus.in_result[1:0] : lo_q;
  assign s_pc  = idle ? bus.in_pc : pc_q;
  assign s_rd  = idle ? bus.in_rd : rd_q;
  assign s_rdw = idle ? bus.in_rd_wen : rdw_q;
  assign s_cw  = idle ? bus.in_csr_wen : cw_q;
  assign s_ca  = idle ? bus.in_csr_addr : ca_q;
  assign s_cd  = idle ? bus.in_csr_wdata : cd_q;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .funct3   (a_f3),
    .addr     (a_lo),
    .raw      (bus.mem_rsp_data),
    .data     (ld_data),
    .misalign (ld_mis)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    rdw_d       = rdw_q;
    lo_d        = lo_q;
    f3_d        = f3_q;
    cw_d        = cw_q;
    ca_d        = ca_q;
    cd_d        = cd_q;
    mrv_d       = mrv_q;
    mra_d       = mra_q;
    rf_wen_d    = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    csr_wen_d   = 1'b0;
    csr_waddr_d = csr_waddr_q;
    csr_wdata_d = csr_wdata_q;
    cv_d        = 1'b0;
    cpc_d       = cpc_q;
    mis_d       = 1'b0;
    go          = 1'b0;
    g_mis       = 1'b0;
    g_data      = bus.in_result;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          pc_d  = bus.in_pc;
          rd_d  = bus.in_rd;
          rdw_d = bus.in_rd_wen;
          lo_d  = bus.in_result[1:0];
          f3_d  = bus.in_funct3;
          cw_d  = bus.in_csr_wen;
          ca_d  = bus.in_csr_addr;
          cd_d  = bus.in_csr_wdata;
          if (!bus.in_is_load) begin
            go = 1'b1;
          end else if (ld_mis) begin
            go    = 1'b1;
            g_mis = 1'b1;
          end else begin
            state_d = MEM_REQ;
            mrv_d   = 1'b1;
            mra_d   = {bus.in_result[XLEN-1:2], 2'b00};
          end
        end
      end
      MEM_REQ: begin
        if (bus.mem_req_ready) begin
          mrv_d   = 1'b0;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_rsp_valid) begin
          go     = 1'b1;
          g_data = ld_data;
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (go) begin
      state_d     = COMMIT;
      cv_d        = 1'b1;
      cpc_d       = s_pc;
      rf_wen_d    = s_rdw & (|s_rd) & ~g_mis;
      rf_waddr_d  = s_rd;
      if (!g_mis)
        rf_wdata_d = g_data;
      csr_wen_d   = s_cw & ~g_mis;
      csr_waddr_d = s_ca;
      csr_wdata_d = s_cd;
      mis_d       = g_mis;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      rd_q        <= '0;
      rdw_q       <= 1'b0;
      lo_q        <= '0;
      f3_q        <= '0;
      cw_q        <= 1'b0;
      ca_q        <= '0;
      cd_q        <= '0;
      mrv_q       <= 1'b0;
      mra_q       <= '0;
      rf_wen_q    <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      csr_wen_q   <= 1'b0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
      cv_q        <= 1'b0;
      cpc_q       <= '0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      rdw_q       <= rdw_d;
      lo_q        <= lo_d;
      f3_q        <= f3_d;
      cw_q        <= cw_d;
      ca_q        <= ca_d;
      cd_q        <= cd_d;
      mrv_q       <= mrv_d;
      mra_q       <= mra_d;
      rf_wen_q    <= rf_wen_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      csr_wen_q   <= csr_wen_d;
      csr_waddr_q <= csr_waddr_d;
      csr_wdata_q <= csr_wdata_d;
      cv_q        <= cv_d;
      cpc_q       <= cpc_d;
      mis_q       <= mis_d;
    end
  end

  assign bus.in_ready      = idle;
  assign bus.mem_req_valid = mrv_q;
  assign bus.mem_req_addr  = mra_q;
  assign bus.rf_wen        = rf_wen_q;
  assign bus.rf_waddr      = rf_waddr_q;
  assign bus.rf_wdata      = rf_wdata_q;
  assign bus.csr_wen       = csr_wen_q;
  assign bus.csr_waddr     = csr_waddr_q;
  assign bus.csr_wdata     = csr_wdata_q;
  assign bus.commit_valid  = cv_q;
  assign bus.commit_pc     = cpc_q;
  assign bus.load_misalign = mis_q;

endmodule
